// File: rtl/mac_kbd_pkg.sv
// mac_kbd_pkg: shared constants, types and key translation for the M0110A keyboard bridge.
//   - Mac command / response byte constants.
//   - Command FSM state enum.
//   - ps2_to_mac(): set-2 scancode {extended, code} -> {valid, keypad, Mac keycode K}.
//   - mac_trans_byte(): Mac keycode + press flag -> transition byte.
// Build option: MAC_KBD_KEYPAD_PREFIX_EN adds the keypad and arrow keys, which are sent as a
// two-byte sequence (KEYPAD_PREFIX, then the transition byte). Without it they are unmapped.
package mac_kbd_pkg;

  localparam logic [7:0] CMD_INQUIRY   = 8'h10;
  localparam logic [7:0] CMD_INSTANT   = 8'h14;
  localparam logic [7:0] CMD_MODEL     = 8'h16;
  localparam logic [7:0] CMD_TEST      = 8'h36;

  localparam logic [7:0] RSP_NULL      = 8'h7B;
  localparam logic [7:0] RSP_MODEL     = 8'h0B;
  localparam logic [7:0] RSP_ACK       = 8'h7D;
  localparam logic [7:0] KEYPAD_PREFIX = 8'h79;

  localparam logic [6:0] MAC_CAPS_LOCK = 7'h39;

  typedef enum logic [1:0] {
    StIdle,
    StWaitKey,
    StRespond
  } bridge_state_e;

  typedef struct packed {
    logic       valid;
    logic       keypad;
    logic [6:0] code;
  } mac_key_t;

  // Byte is (K << 1) | 1 truncated to 8 bits; release additionally forces bit 7.
  function automatic logic [7:0] mac_trans_byte(input logic [6:0] code, input logic pressed);
    return {code[6] | ~pressed, code[5:0], 1'b1};
  endfunction

  function automatic mac_key_t ps2_to_mac(input logic ext, input logic [7:0] sc);
    mac_key_t r;
    r.valid  = 1'b1;
    r.keypad = 1'b0;
    r.code   = 7'h00;
    case ({ext, sc})
      9'h01C: r.code = 7'h00;  // A
      9'h01B: r.code = 7'h01;  // S
      9'h023: r.code = 7'h02;  // D
      9'h02B: r.code = 7'h03;  // F
      9'h033: r.code = 7'h04;  // H
      9'h034: r.code = 7'h05;  // G
      9'h01A: r.code = 7'h06;  // Z
      9'h022: r.code = 7'h07;  // X
      9'h021: r.code = 7'h08;  // C
      9'h02A: r.code = 7'h09;  // V
      9'h032: r.code = 7'h0B;  // B
      9'h015: r.code = 7'h0C;  // Q
      9'h01D: r.code = 7'h0D;  // W
      9'h024: r.code = 7'h0E;  // E
      9'h02D: r.code = 7'h0F;  // R
      9'h035: r.code = 7'h10;  // Y
      9'h02C: r.code = 7'h11;  // T
      9'h016: r.code = 7'h12;  // 1
      9'h01E: r.code = 7'h13;  // 2
      9'h026: r.code = 7'h14;  // 3
      9'h025: r.code = 7'h15;  // 4
      9'h036: r.code = 7'h16;  // 6
      9'h02E: r.code = 7'h17;  // 5
      9'h055: r.code = 7'h18;  // =
      9'h046: r.code = 7'h19;  // 9
      9'h03D: r.code = 7'h1A;  // 7
      9'h04E: r.code = 7'h1B;  // -
      9'h03E: r.code = 7'h1C;  // 8
      9'h045: r.code = 7'h1D;  // 0
      9'h05B: r.code = 7'h1E;  // ]
      9'h044: r.code = 7'h1F;  // O
      9'h03C: r.code = 7'h20;  // U
      9'h054: r.code = 7'h21;  // [
      9'h043: r.code = 7'h22;  // I
      9'h04D: r.code = 7'h23;  // P
      9'h05A: r.code = 7'h24;  // Return
      9'h04B: r.code = 7'h25;  // L
      9'h03B: r.code = 7'h26;  // J
      9'h052: r.code = 7'h27;  // '
      9'h042: r.code = 7'h28;  // K
      9'h04C: r.code = 7'h29;  // ;
      9'h05D: r.code = 7'h2A;  // backslash
      9'h041: r.code = 7'h2B;  // ,
      9'h04A: r.code = 7'h2C;  // /
      9'h031: r.code = 7'h2D;  // N
      9'h03A: r.code = 7'h2E;  // M
      9'h049: r.code = 7'h2F;  // .
      9'h00D: r.code = 7'h30;  // Tab
      9'h029: r.code = 7'h31;  // Space
      9'h00E: r.code = 7'h32;  // `
      9'h066: r.code = 7'h33;  // Backspace
      9'h014: r.code = 7'h37;  // Left Ctrl -> Command
      9'h012: r.code = 7'h38;  // Left Shift
      9'h059: r.code = 7'h38;  // Right Shift
      9'h058: r.code = MAC_CAPS_LOCK;
      9'h011: r.code = 7'h3A;  // Left Alt -> Option
      9'h111: r.code = 7'h3A;  // Right Alt -> Option
      9'h114: r.code = 7'h37;  // Right Ctrl -> Command
      9'h11F: r.code = 7'h37;  // Left GUI -> Command
      9'h127: r.code = 7'h37;  // Right GUI -> Command
`ifdef MAC_KBD_KEYPAD_PREFIX_EN
      9'h070: begin r.keypad = 1'b1; r.code = 7'h52; end  // KP0
      9'h069: begin r.keypad = 1'b1; r.code = 7'h53; end  // KP1
      9'h072: begin r.keypad = 1'b1; r.code = 7'h54; end  // KP2
      9'h07A: begin r.keypad = 1'b1; r.code = 7'h55; end  // KP3
      9'h06B: begin r.keypad = 1'b1; r.code = 7'h56; end  // KP4
      9'h073: begin r.keypad = 1'b1; r.code = 7'h57; end  // KP5
      9'h074: begin r.keypad = 1'b1; r.code = 7'h58; end  // KP6
      9'h06C: begin r.keypad = 1'b1; r.code = 7'h59; end  // KP7
      9'h075: begin r.keypad = 1'b1; r.code = 7'h5B; end  // KP8
      9'h07D: begin r.keypad = 1'b1; r.code = 7'h5C; end  // KP9
      9'h071: begin r.keypad = 1'b1; r.code = 7'h41; end  // KP.
      9'h079: begin r.keypad = 1'b1; r.code = 7'h45; end  // KP+
      9'h07B: begin r.keypad = 1'b1; r.code = 7'h4E; end  // KP-
      9'h07C: begin r.keypad = 1'b1; r.code = 7'h43; end  // KP*
      9'h175: begin r.keypad = 1'b1; r.code = 7'h3E; end  // Up
      9'h172: begin r.keypad = 1'b1; r.code = 7'h3D; end  // Down
      9'h16B: begin r.keypad = 1'b1; r.code = 7'h3B; end  // Left
      9'h174: begin r.keypad = 1'b1; r.code = 7'h3C; end  // Right
`endif
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mac_kbd_bridge_if.sv
// mac_kbd_bridge_if: byte handshake between the Mac keyboard shifter and the bridge.
//   data_out / strobe_out : command byte from the Mac, valid for one ce tick.
//   data_in  / strobe_in  : response byte to the Mac, valid for one ce tick.
// Modports: master = Mac side, slave = keyboard bridge.
interface mac_kbd_bridge_if;
  logic [7:0] data_out;
  logic       strobe_out;
  logic [7:0] data_in;
  logic       strobe_in;

  modport master (
    output data_out,
    output strobe_out,
    input  data_in,
    input  strobe_in
  );

  modport slave (
    input  data_out,
    input  strobe_out,
    output data_in,
    output strobe_in
  );
endinterface

// File: rtl/mac_kbd_fifo.sv
// mac_kbd_fifo: synchronous 8-bit FIFO of Mac key-transition bytes.
//   clk, reset     : clock, synchronous active-high reset.
//   clear_i        : empty the queue (takes priority over push/pop).
//   push_i         : append wdata0_i when not full.
//   push_two_i     : append wdata0_i then wdata1_i when two slots are free, else nothing.
//   pop_i          : drop the head when not empty.
//   rdata_o        : head byte (valid when !empty_o).
//   full_o, empty_o, free_o : occupancy status.
// FIFO_DEPTH must be a power of two and at least 2. Callers gate push/pop with ce.
module mac_kbd_fifo #(
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            push_two_i,
  input  logic [7:0]      wdata0_i,
  input  logic [7:0]      wdata1_i,
  input  logic            pop_i,
  output logic [7:0]      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] free_o
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push1, do_push2, do_pop;

  always_comb begin
    free_o   = CntW'(FIFO_DEPTH) - count_q;
    full_o   = (count_q == CntW'(FIFO_DEPTH));
    empty_o  = (count_q == CntW'(0));
    rdata_o  = mem_q[rptr_q];
    // Space is judged before any same-cycle pop so a pair never overruns the head.
    do_push2 = push_two_i && (free_o >= CntW'(2));
    do_push1 = push_i && !push_two_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push2) begin
        wptr_d = wptr_q + AddrW'(2);
      end else if (do_push1) begin
        wptr_d = wptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AddrW'(1);
      end
      count_d = count_q
              + (do_push2 ? CntW'(2) : (do_push1 ? CntW'(1) : CntW'(0)))
              - (do_pop ? CntW'(1) : CntW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear_i) begin
      if (do_push1 || do_push2) begin
        mem_q[wptr_q] <= wdata0_i;
      end
      if (do_push2) begin
        mem_q[wptr_q + AddrW'(1)] <= wdata1_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mac_kbd_bridge.sv
// mac_kbd_bridge: emulates a Macintosh M0110A keyboard for the VIA keyboard shifter.
// PS/2 key events are translated to Mac transition bytes and queued; Mac commands
// (Inquiry, Instant, Model, Test) are answered with one response byte each.
//   clk, reset : clock, synchronous active-high reset.
//   ce         : clock enable; all state advances only when ce=1.
//   ps2_key    : [10] toggles per event, [9] pressed, [8] E0-extended, [7:0] set-2 code.
//   mac        : command/response handshake (slave side of mac_kbd_bridge_if).
//   capslock   : caps-lock latch state.
// Build option: MAC_KBD_KEYPAD_PREFIX_EN enables prefixed keypad/arrow keys (see mac_kbd_pkg).
module mac_kbd_bridge
  import mac_kbd_pkg::*;
#(
  parameter int unsigned INQUIRY_TIMEOUT = 2000000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [10:0]            ps2_key,
  mac_kbd_bridge_if.slave        mac,
  output logic                   capslock
);

  localparam int unsigned TimerW    = (INQUIRY_TIMEOUT > 1) ? $clog2(INQUIRY_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(INQUIRY_TIMEOUT - 1);
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);

  bridge_state_e     state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              toggle_q;
  logic              capslock_q, capslock_d;

  logic              key_event;
  mac_key_t          key;
  logic [7:0]        key_byte;

  logic              fifo_clear, fifo_push, fifo_push_two, fifo_pop;
  logic [7:0]        fifo_wdata0, fifo_wdata1, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_free;

  mac_kbd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (fifo_clear),
    .push_i     (fifo_push),
    .push_two_i (fifo_push_two),
    .wdata0_i   (fifo_wdata0),
    .wdata1_i   (fifo_wdata1),
    .pop_i      (fifo_pop),
    .rdata_o    (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_o     (fifo_free)
  );

  // Key path: runs in every FSM state.
  always_comb begin
    key_event     = ce && (ps2_key[10] != toggle_q);
    key           = ps2_to_mac(ps2_key[8], ps2_key[7:0]);
    key_byte      = mac_trans_byte(key.code, ps2_key[9]);
    capslock_d    = capslock_q;
    fifo_push     = 1'b0;
    fifo_push_two = 1'b0;
    fifo_wdata0   = key_byte;
    fifo_wdata1   = key_byte;
    if (key_event && key.valid) begin
      if (key.keypad) begin
        // Prefix and key travel together or not at all.
        fifo_push_two = (fifo_free >= CntW'(2));
        fifo_wdata0   = KEYPAD_PREFIX;
      end else if (key.code == MAC_CAPS_LOCK) begin
        // Caps Lock is a latch on the Mac side: PS/2 press toggles, release is ignored.
        if (ps2_key[9]) begin
          capslock_d  = ~capslock_q;
          fifo_push   = !fifo_full;
          fifo_wdata0 = mac_trans_byte(MAC_CAPS_LOCK, ~capslock_q);
        end
      end else begin
        fifo_push = !fifo_full;
      end
    end
  end

  // Command FSM.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    data_in_d  = data_in_q;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    if (ce) begin
      if (mac.strobe_out) begin
        // A new command always wins, including over a pending Inquiry.
        timer_d = '0;
        state_d = StRespond;
        case (mac.data_out)
          CMD_INQUIRY: begin
            if (!fifo_empty) begin
              data_in_d = fifo_rdata;
              fifo_pop  = 1'b1;
            end else begin
              state_d = StWaitKey;
            end
          end
          CMD_INSTANT: begin
            if (!fifo_empty) begin
              data_in_d = fifo_rdata;
              fifo_pop  = 1'b1;
            end else begin
              data_in_d = RSP_NULL;
            end
          end
          CMD_MODEL: begin
            fifo_clear = 1'b1;
            data_in_d  = RSP_MODEL;
          end
          CMD_TEST: data_in_d = RSP_ACK;
          default:  data_in_d = RSP_NULL;
        endcase
      end else begin
        unique case (state_q)
          StIdle: ;
          StWaitKey: begin
            if (!fifo_empty) begin
              data_in_d = fifo_rdata;
              fifo_pop  = 1'b1;
              state_d   = StRespond;
            end else if (timer_q == TimerLast) begin
              data_in_d = RSP_NULL;
              state_d   = StRespond;
            end else begin
              timer_d = timer_q + TimerW'(1);
            end
          end
          StRespond: state_d = StIdle;
          default:   state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      data_in_q  <= 8'h00;
      capslock_q <= 1'b0;
      // Track the current toggle so leaving reset is not seen as a key event.
      toggle_q   <= ps2_key[10];
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      data_in_q  <= data_in_d;
      capslock_q <= capslock_d;
      if (ce) begin
        toggle_q <= ps2_key[10];
      end
    end
  end

  assign mac.data_in   = data_in_q;
  assign mac.strobe_in = (state_q == StRespond);
  assign capslock      = capslock_q;

endmodule

// File: tb/tb_mac_kbd_bridge.sv
// tb_mac_kbd_bridge: self-checking bench for mac_kbd_bridge with a queue-based reference model.
module tb_mac_kbd_bridge;

  localparam int unsigned Timeout = 100;
  localparam int unsigned Depth   = 8;

  localparam int KindPlain = 0;
  localparam int KindCaps  = 1;
  localparam int KindPad   = 2;
  localparam int KindNone  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [10:0] ps2_key;
  logic        capslock;

  mac_kbd_bridge_if mac_if ();

  mac_kbd_bridge #(
    .INQUIRY_TIMEOUT (Timeout),
    .FIFO_DEPTH      (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .ps2_key  (ps2_key),
    .mac      (mac_if.slave),
    .capslock (capslock)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ext;
    bit [7:0] sc;
    int       kind;
    int       k;
  } key_t;

  key_t        keys[9];
  int          n_cmp = 0;
  int          n_bad = 0;
  byte unsigned exp_q[$];
  bit          caps_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic byte unsigned trans(input int k, input bit pressed);
    int v;
    v = (k * 2 + 1) % 256;
    if (!pressed) v = v | 128;
    return byte'(v);
  endfunction

  function automatic void model_push(input byte unsigned b);
    if (exp_q.size() < Depth) exp_q.push_back(b);
  endfunction

  function automatic void model_key(input key_t kk, input bit pressed);
    case (kk.kind)
      KindPlain: model_push(trans(kk.k, pressed));
      KindCaps: begin
        if (pressed) begin
          caps_m = !caps_m;
          model_push(caps_m ? 8'h73 : 8'hF3);
        end
      end
      KindPad: begin
`ifdef MAC_KBD_KEYPAD_PREFIX_EN
        if (int'(Depth) - exp_q.size() >= 2) begin
          exp_q.push_back(8'h79);
          exp_q.push_back(trans(kk.k, pressed));
        end
`endif
      end
      default: ;
    endcase
  endfunction

  task automatic hit_key(input int idx, input bit pressed);
    ps2_key = {~ps2_key[10], pressed, keys[idx].ext, keys[idx].sc};
    step();
    model_key(keys[idx], pressed);
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    byte unsigned exp;
    case (cmd)
      8'h10, 8'h14: exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h7B;
      8'h16: begin
        exp_q.delete();
        exp = 8'h0B;
      end
      8'h36:   exp = 8'h7D;
      default: exp = 8'h7B;
    endcase
    mac_if.data_out   = cmd;
    mac_if.strobe_out = 1'b1;
    step();
    mac_if.strobe_out = 1'b0;
    check_eq($sformatf("strobe_in after cmd %02h", cmd), mac_if.strobe_in, 1);
    check_eq($sformatf("data_in after cmd %02h", cmd), mac_if.data_in, exp);
    step();
    check_eq($sformatf("strobe_in single tick cmd %02h", cmd), mac_if.strobe_in, 0);
  endtask

  // Inquiry on an empty queue; optionally press Space on tick inject_at.
  task automatic inquiry_wait(input int inject_at);
    int          seen;
    logic [7:0]  got;
    int          exp_lat;
    byte unsigned exp_data;
    seen = 0;
    got  = 8'h00;
    mac_if.data_out   = 8'h10;
    mac_if.strobe_out = 1'b1;
    step();
    mac_if.strobe_out = 1'b0;
    check_eq("inquiry no immediate strobe", mac_if.strobe_in, 0);
    for (int t = 1; t <= int'(Timeout) + 20 && seen == 0; t++) begin
      if (t == inject_at) ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
      step();
      if (mac_if.strobe_in) begin
        seen = t;
        got  = mac_if.data_in;
      end
    end
    if (inject_at > 0) begin
      exp_lat  = inject_at + 1;
      exp_data = trans('h31, 1'b1);
    end else begin
      exp_lat  = int'(Timeout);
      exp_data = 8'h7B;
    end
    check_eq($sformatf("inquiry latency inject=%0d", inject_at), seen, exp_lat);
    check_eq($sformatf("inquiry data inject=%0d", inject_at), got, exp_data);
    step();
    check_eq("inquiry strobe single tick", mac_if.strobe_in, 0);
  endtask

  initial begin
    int strobes;
    int r;
    logic [7:0] c;

    keys[0] = '{ext: 1'b0, sc: 8'h1C, kind: KindPlain, k: 'h00};  // A
    keys[1] = '{ext: 1'b0, sc: 8'h29, kind: KindPlain, k: 'h31};  // Space
    keys[2] = '{ext: 1'b0, sc: 8'h5A, kind: KindPlain, k: 'h24};  // Return
    keys[3] = '{ext: 1'b0, sc: 8'h12, kind: KindPlain, k: 'h38};  // Left Shift
    keys[4] = '{ext: 1'b0, sc: 8'h59, kind: KindPlain, k: 'h38};  // Right Shift
    keys[5] = '{ext: 1'b0, sc: 8'h58, kind: KindCaps,  k: 'h39};  // Caps Lock
    keys[6] = '{ext: 1'b0, sc: 8'h70, kind: KindPad,   k: 'h52};  // KP0
    keys[7] = '{ext: 1'b0, sc: 8'h07, kind: KindNone,  k: 0};     // F12, unmapped
    keys[8] = '{ext: 1'b1, sc: 8'h1C, kind: KindNone,  k: 0};     // E0 1C, unmapped

    ce                = 1'b1;
    ps2_key           = 11'h400;
    mac_if.data_out   = 8'h00;
    mac_if.strobe_out = 1'b0;
    reset             = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_eq("reset data_in", mac_if.data_in, 8'h00);
    check_eq("reset strobe_in", mac_if.strobe_in, 0);
    check_eq("reset capslock", capslock, 0);
    step();
    check_eq("idle after reset strobe_in", mac_if.strobe_in, 0);

    // Test command, then no spurious event from reset.
    send_cmd(8'h36);
    check_eq("capslock after test", capslock, 0);
    send_cmd(8'h14);

    // Press/release A.
    hit_key(0, 1'b1);
    send_cmd(8'h14);
    hit_key(0, 1'b0);
    send_cmd(8'h10);
    send_cmd(8'h14);

    // Inquiry timeout and inquiry answered by a key.
    inquiry_wait(-1);
    inquiry_wait(40);

    // Caps Lock press, release, press.
    hit_key(5, 1'b1);
    check_eq("capslock after press 1", capslock, 1);
    hit_key(5, 1'b0);
    check_eq("capslock after release", capslock, 1);
    hit_key(5, 1'b1);
    check_eq("capslock after press 2", capslock, 0);
    repeat (3) send_cmd(8'h14);

    // Overflow: nine presses into eight slots, drained.
    for (int i = 0; i < 9; i++) hit_key($urandom_range(0, 4), 1'b1);
    repeat (9) send_cmd(8'h14);
    // Overflow then Model clears.
    for (int i = 0; i < 9; i++) hit_key($urandom_range(0, 4), 1'b1);
    send_cmd(8'h16);
    send_cmd(8'h14);

    // Keypad key, then keypad pair with only one slot free.
    hit_key(6, 1'b1);
    send_cmd(8'h14);
    send_cmd(8'h14);
    for (int i = 0; i < 7; i++) hit_key($urandom_range(0, 4), 1'b0);
    hit_key(6, 1'b1);
    hit_key(0, 1'b1);
    repeat (9) send_cmd(8'h14);

    // Pending Inquiry aborted by a new command.
    mac_if.data_out   = 8'h10;
    mac_if.strobe_out = 1'b1;
    step();
    mac_if.strobe_out = 1'b0;
    strobes = 0;
    repeat (10) begin
      step();
      if (mac_if.strobe_in) strobes++;
    end
    check_eq("no strobe before abort", strobes, 0);
    send_cmd(8'h36);
    strobes = 0;
    repeat (Timeout + 20) begin
      step();
      if (mac_if.strobe_in) strobes++;
    end
    check_eq("no strobe after abort", strobes, 0);

    // ce gating: nothing advances while ce=0.
    ce                = 1'b0;
    ps2_key           = {~ps2_key[10], 1'b1, keys[0].ext, keys[0].sc};
    mac_if.data_out   = 8'h36;
    mac_if.strobe_out = 1'b1;
    strobes = 0;
    repeat (3) begin
      step();
      if (mac_if.strobe_in) strobes++;
    end
    check_eq("no strobe with ce low", strobes, 0);
    mac_if.strobe_out = 1'b0;
    ce = 1'b1;
    step();
    model_key(keys[0], 1'b1);
    send_cmd(8'h14);

    // Reset in the middle of a pending Inquiry.
    send_cmd(8'h16);
    if (!caps_m) hit_key(5, 1'b1);
    send_cmd(8'h14);
    check_eq("capslock set before reset", capslock, 1);
    mac_if.data_out   = 8'h10;
    mac_if.strobe_out = 1'b1;
    step();
    mac_if.strobe_out = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    caps_m = 1'b0;
    check_eq("mid-wait reset capslock", capslock, 0);
    check_eq("mid-wait reset data_in", mac_if.data_in, 8'h00);
    strobes = 0;
    repeat (Timeout + 20) begin
      step();
      if (mac_if.strobe_in) strobes++;
    end
    check_eq("no strobe after mid-wait reset", strobes, 0);
    send_cmd(8'h14);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        hit_key($urandom_range(0, 8), 1'($urandom_range(0, 1)));
        check_eq("random capslock", capslock, caps_m);
      end else if (r < 9) begin
        case ($urandom_range(0, 9))
          0, 1, 2: c = 8'h10;
          3, 4, 5: c = 8'h14;
          6:       c = 8'h16;
          7:       c = 8'h36;
          default: c = 8'($urandom_range(0, 255));
        endcase
        if (c == 8'h10 && exp_q.size() == 0) c = 8'h14;
        send_cmd(c);
      end else begin
        step();
        check_eq("random idle strobe_in", mac_if.strobe_in, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
